// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the MIPS instruction-decode stage:
// opcodes, ALUOp encodings, instruction field positions and the control decoder.
package id_stage_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int JT_MSB  = 25;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   reg_write;
        logic   mem_to_reg;
        logic   mem_read;
        logic   mem_write;
        logic   alu_src;
        logic   reg_dst;
        aluop_e alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        ex_ctrl_t ex;
        logic     branch;
        logic     jump;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        c = '0;
        // An all-zero word shares the R-type opcode but must decode as a nop.
        if (inst != '0) begin
            case (inst[OP_MSB:OP_LSB])
                OP_RTYPE: begin
                    c.ex.reg_write = 1'b1;
                    c.ex.reg_dst   = 1'b1;
                    c.ex.alu_op    = ALUOP_FUNCT;
                end
                OP_ADDI: begin
                    c.ex.reg_write = 1'b1;
                    c.ex.alu_src   = 1'b1;
                end
                OP_LW: begin
                    c.ex.reg_write  = 1'b1;
                    c.ex.mem_to_reg = 1'b1;
                    c.ex.mem_read   = 1'b1;
                    c.ex.alu_src    = 1'b1;
                end
                OP_SW: begin
                    c.ex.mem_write = 1'b1;
                    c.ex.alu_src   = 1'b1;
                end
                OP_BEQ: begin
                    c.branch    = 1'b1;
                    c.ex.alu_op = ALUOP_SUB;
                end
                OP_J:    c.jump = 1'b1;
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: 2 combinational read ports with write-through bypass,
// 1 write port, r0 hard-wired to zero, asynchronous clear.
module id_stage_reg_file
    import id_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [REG_AW-1:0] rt_addr_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rs_data_o,
    output logic [XLEN-1:0]   rt_data_o
);

    logic [XLEN-1:0] regs_d [NREG];
    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr_i] = wdata_i;
    end

    // NOTE: the register array is explicitly reset because software may read it before writing it.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) regs_q <= '{default: '0};
        else          regs_q <= regs_d;
    end

    always_comb begin
        rs_data_o = regs_q[rs_addr_i];
        if (rs_addr_i == '0)                    rs_data_o = '0;
        else if (wr_en && rs_addr_i == waddr_i) rs_data_o = wdata_i;

        rt_data_o = regs_q[rt_addr_i];
        if (rt_addr_i == '0)                    rt_data_o = '0;
        else if (wr_en && rt_addr_i == waddr_i) rt_data_o = wdata_i;
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: control decode, register read, load-use
// hazard detection, beq/j resolution and the ID/EX pipeline register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    input  logic              RegWrite_wb_i,
    input  logic [REG_AW-1:0] RdAddr_wb_i,
    input  logic [XLEN-1:0]   RdData_wb_i,
    output logic              Stall_o,
    output logic              Jump_o,
    output logic              Branch_o,
    output logic              Eq_o,
    output logic [XLEN-1:0]   JumpPC_o,
    output logic [XLEN-1:0]   BranchPC_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic [1:0]        ALUOp_o,
    output logic [XLEN-1:0]   RsData_o,
    output logic [XLEN-1:0]   RtData_o,
    output logic [XLEN-1:0]   Imm_o,
    output logic [REG_AW-1:0] RsAddr_o,
    output logic [REG_AW-1:0] RtAddr_o,
    output logic [REG_AW-1:0] RdAddr_o
);

    typedef struct packed {
        ex_ctrl_t          ctrl;
        logic [XLEN-1:0]   rs_data;
        logic [XLEN-1:0]   rt_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } idex_t;

    ctrl_t             ctrl;
    idex_t             idex_d, idex_q;
    logic [REG_AW-1:0] rs_a, rt_a, rd_a;
    logic [XLEN-1:0]   rs_data, rt_data, imm;

    assign ctrl = decode(inst_i);
    assign rs_a = inst_i[RS_MSB:RS_LSB];
    assign rt_a = inst_i[RT_MSB:RT_LSB];
    assign rd_a = inst_i[RD_MSB:RD_LSB];
    assign imm  = {{(XLEN-16){inst_i[IMM_MSB]}}, inst_i[IMM_MSB:0]};

    id_stage_reg_file #(.NREG(NREG), .XLEN(XLEN)) u_reg_file (
        .clk_i     (clk_i),
        .start_i   (start_i),
        .rs_addr_i (rs_a),
        .rt_addr_i (rt_a),
        .we_i      (RegWrite_wb_i),
        .waddr_i   (RdAddr_wb_i),
        .wdata_i   (RdData_wb_i),
        .rs_data_o (rs_data),
        .rt_data_o (rt_data)
    );

    // A load in EX whose target feeds either source of the ID instruction stalls one cycle.
    assign Stall_o = idex_q.ctrl.mem_read && (idex_q.rt != '0) &&
                     ((idex_q.rt == rs_a) || (idex_q.rt == rt_a));

    assign Eq_o       = (rs_data == rt_data);
    assign Branch_o   = ctrl.branch && !Stall_o;
    assign Jump_o     = ctrl.jump && !Stall_o;
    assign JumpPC_o   = {pc_i[XLEN-1:XLEN-4], inst_i[JT_MSB:0], 2'b00};
    assign BranchPC_o = pc_i + {imm[XLEN-3:0], 2'b00};

    // beq and j are finished in ID, so they travel down the pipe as bubbles.
    always_comb begin
        idex_d.ctrl    = (Stall_o || ctrl.branch || ctrl.jump) ? '0 : ctrl.ex;
        idex_d.rs_data = rs_data;
        idex_d.rt_data = rt_data;
        idex_d.imm     = imm;
        idex_d.rs      = rs_a;
        idex_d.rt      = rt_a;
        idex_d.rd      = rd_a;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) idex_q <= '0;
        else          idex_q <= idex_d;
    end

    assign RegWrite_o = idex_q.ctrl.reg_write;
    assign MemtoReg_o = idex_q.ctrl.mem_to_reg;
    assign MemRead_o  = idex_q.ctrl.mem_read;
    assign MemWrite_o = idex_q.ctrl.mem_write;
    assign ALUSrc_o   = idex_q.ctrl.alu_src;
    assign RegDst_o   = idex_q.ctrl.reg_dst;
    assign ALUOp_o    = idex_q.ctrl.alu_op;
    assign RsData_o   = idex_q.rs_data;
    assign RtData_o   = idex_q.rt_data;
    assign Imm_o      = idex_q.imm;
    assign RsAddr_o   = idex_q.rs;
    assign RtAddr_o   = idex_q.rt;
    assign RdAddr_o   = idex_q.rd;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage; expected values are hand-computed
// from the MIPS encodings of each instruction.
module tb_id_stage;

    logic        clk_i = 1'b0;
    logic        start_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        RegWrite_wb_i;
    logic [4:0]  RdAddr_wb_i;
    logic [31:0] RdData_wb_i;
    logic        Stall_o, Jump_o, Branch_o, Eq_o;
    logic [31:0] JumpPC_o, BranchPC_o;
    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RsData_o, RtData_o, Imm_o;
    logic [4:0]  RsAddr_o, RtAddr_o, RdAddr_o;

    int vectors = 0;
    int miscompares = 0;

    id_stage dut (
        .clk_i(clk_i), .start_i(start_i), .pc_i(pc_i), .inst_i(inst_i),
        .RegWrite_wb_i(RegWrite_wb_i), .RdAddr_wb_i(RdAddr_wb_i), .RdData_wb_i(RdData_wb_i),
        .Stall_o(Stall_o), .Jump_o(Jump_o), .Branch_o(Branch_o), .Eq_o(Eq_o),
        .JumpPC_o(JumpPC_o), .BranchPC_o(BranchPC_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
        .RsData_o(RsData_o), .RtData_o(RtData_o), .Imm_o(Imm_o),
        .RsAddr_o(RsAddr_o), .RtAddr_o(RtAddr_o), .RdAddr_o(RdAddr_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] ctrl_bits();
        return {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o};
    endfunction

    function automatic logic [118:0] idex_all();
        return {ctrl_bits(), RsData_o, RtData_o, Imm_o, RsAddr_o, RtAddr_o, RdAddr_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        pc_i = pc; inst_i = inst; RegWrite_wb_i = we; RdAddr_wb_i = wa; RdData_wb_i = wd;
        #1;
    endtask

    task automatic test_reset();
        start_i = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        vectors++; if (idex_all() !== '0) begin miscompares++; $display("FAIL reset_idex: got %h expected 0", idex_all()); end
        vectors++; if (Stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", Stall_o); end
        #8 start_i = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        drive(32'h4, 32'h2001_0005, 1'b0, 5'd0, 32'h0);     // addi r1,r0,5
        tick();
        vectors++; if (ctrl_bits() !== 8'b1000_1000) begin miscompares++; $display("FAIL addi_ctrl: got %b expected 10001000", ctrl_bits()); end
        vectors++; if ({Imm_o, RtAddr_o} !== {32'd5, 5'd1}) begin miscompares++; $display("FAIL addi_imm_rt: got %h/%0d expected 5/1", Imm_o, RtAddr_o); end
        drive(32'h8, 32'h0, 1'b1, 5'd1, 32'd5);              // writeback r1=5
        tick();
        drive(32'hC, 32'h2020_0000, 1'b0, 5'd0, 32'h0);     // addi r0,r1,0 reads r1
        tick();
        vectors++; if (RsData_o !== 32'd5) begin miscompares++; $display("FAIL r1_read: got %h expected 5", RsData_o); end
    endtask

    task automatic test_bypass();
        drive(32'h10, 32'h0040_2820, 1'b1, 5'd2, 32'hA5A5_A5A5); // add r5,r2,r0 with r2 writeback
        tick();
        vectors++; if (RsData_o !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL bypass_r2: got %h expected a5a5a5a5", RsData_o); end
        vectors++; if ({RegDst_o, ALUOp_o, RdAddr_o} !== {1'b1, 2'b10, 5'd5}) begin miscompares++; $display("FAIL rtype_ctrl: got %b%b/%0d expected 110/5", RegDst_o, ALUOp_o, RdAddr_o); end
        drive(32'h10, 32'h0040_2820, 1'b0, 5'd0, 32'h0);
        tick();
        vectors++; if (RsData_o !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL stored_r2: got %h expected a5a5a5a5", RsData_o); end
        drive(32'h14, 32'h0000_2820, 1'b1, 5'd0, 32'd7);     // add r5,r0,r0 with r0 writeback
        tick();
        vectors++; if (RsData_o !== 32'h0) begin miscompares++; $display("FAIL r0_bypass: got %h expected 0", RsData_o); end
        drive(32'h14, 32'h0000_2820, 1'b0, 5'd0, 32'h0);
        tick();
        vectors++; if (RtData_o !== 32'h0) begin miscompares++; $display("FAIL r0_stored: got %h expected 0", RtData_o); end
    endtask

    task automatic test_load_use();
        drive(32'h18, 32'h8C03_0000, 1'b0, 5'd0, 32'h0);     // lw r3,0(r0)
        vectors++; if (Stall_o !== 1'b0) begin miscompares++; $display("FAIL lw_no_stall: got %b expected 0", Stall_o); end
        tick();
        vectors++; if (ctrl_bits() !== 8'b1110_1000) begin miscompares++; $display("FAIL lw_ctrl: got %b expected 11101000", ctrl_bits()); end
        drive(32'h1C, 32'h0063_2020, 1'b0, 5'd0, 32'h0);     // add r4,r3,r3
        vectors++; if (Stall_o !== 1'b1) begin miscompares++; $display("FAIL load_use_stall: got %b expected 1", Stall_o); end
        tick();
        vectors++; if (ctrl_bits() !== 8'h00) begin miscompares++; $display("FAIL bubble_ctrl: got %b expected 0", ctrl_bits()); end
        vectors++; if (Stall_o !== 1'b0) begin miscompares++; $display("FAIL stall_one_cycle: got %b expected 0", Stall_o); end
        tick();
        vectors++; if ({RegWrite_o, RdAddr_o} !== {1'b1, 5'd4}) begin miscompares++; $display("FAIL add_after_stall: got %b/%0d expected 1/4", RegWrite_o, RdAddr_o); end
    endtask

    task automatic test_branch();
        drive(32'h20, 32'h1021_FFFE, 1'b0, 5'd0, 32'h0);     // beq r1,r1,-2
        vectors++; if ({Branch_o, Eq_o, Stall_o} !== 3'b110) begin miscompares++; $display("FAIL beq_taken: got %b expected 110", {Branch_o, Eq_o, Stall_o}); end
        vectors++; if (BranchPC_o !== 32'h18) begin miscompares++; $display("FAIL beq_target: got %h expected 18", BranchPC_o); end
        tick();
        vectors++; if ({RegWrite_o, MemRead_o, MemWrite_o} !== 3'b000) begin miscompares++; $display("FAIL beq_bubble: got %b expected 000", {RegWrite_o, MemRead_o, MemWrite_o}); end
        drive(32'h24, 32'h1022_FFFE, 1'b0, 5'd0, 32'h0);     // beq r1,r2,-2
        vectors++; if ({Branch_o, Eq_o} !== 2'b10) begin miscompares++; $display("FAIL beq_not_equal: got %b expected 10", {Branch_o, Eq_o}); end
        tick();
    endtask

    task automatic test_jump();
        drive(32'h10, 32'h0800_0040, 1'b0, 5'd0, 32'h0);     // j 0x40
        vectors++; if ({Jump_o, Branch_o} !== 2'b10) begin miscompares++; $display("FAIL jump: got %b expected 10", {Jump_o, Branch_o}); end
        vectors++; if (JumpPC_o !== 32'h100) begin miscompares++; $display("FAIL jump_target: got %h expected 100", JumpPC_o); end
        tick();
        drive(32'h14, 32'h8C05_0000, 1'b0, 5'd0, 32'h0);     // lw r5,0(r0)
        tick();
        drive(32'h18, 32'h10A0_0001, 1'b0, 5'd0, 32'h0);     // beq r5,r0,+1
        vectors++; if ({Stall_o, Branch_o} !== 2'b10) begin miscompares++; $display("FAIL beq_load_stall: got %b expected 10", {Stall_o, Branch_o}); end
        tick();
        vectors++; if ({Stall_o, Branch_o} !== 2'b01) begin miscompares++; $display("FAIL beq_after_stall: got %b expected 01", {Stall_o, Branch_o}); end
    endtask

    task automatic test_async_reset();
        drive(32'h30, 32'h2001_0005, 1'b0, 5'd0, 32'h0);     // addi r1,r0,5
        tick();
        vectors++; if (RegWrite_o !== 1'b1) begin miscompares++; $display("FAIL pre_reset_state: got %b expected 1", RegWrite_o); end
        #2 start_i = 1'b0;
        #1;
        vectors++; if (idex_all() !== '0) begin miscompares++; $display("FAIL async_reset_idex: got %h expected 0", idex_all()); end
        #1 start_i = 1'b1;
        drive(32'h34, 32'h2020_0000, 1'b0, 5'd0, 32'h0);     // addi r0,r1,0
        tick();
        vectors++; if ({RegWrite_o, RsData_o} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL r1_after_reset: got %b/%h expected 1/0", RegWrite_o, RsData_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_branch();
        test_jump();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
